// File: rtl/time_set_pkg.sv
// Shared types, field encodings, ranges and wrap-around step helpers for the time-setting controller.
package time_set_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR   = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MINUTE = 6'd59;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    COMMIT    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE    = 2'b00,
    FIELD_HOURS   = 2'b01,
    FIELD_MINUTES = 2'b10,
    FIELD_COMMIT  = 2'b11
  } field_e;

  function automatic field_e field_of(input state_e st);
    case (st)
      EDIT_HOUR: return FIELD_HOURS;
      EDIT_MIN:  return FIELD_MINUTES;
      COMMIT:    return FIELD_COMMIT;
      default:   return FIELD_NONE;
    endcase
  endfunction

  // Out-of-range inputs snap to a legal value so nothing illegal is ever driven.
  function automatic logic [HOUR_W-1:0] hour_step(input logic [HOUR_W-1:0] v, input logic up);
    if (up) return (v >= MAX_HOUR) ? '0 : v + 1'b1;
    return (v == '0 || v > MAX_HOUR) ? MAX_HOUR : v - 1'b1;
  endfunction

  function automatic logic [MIN_W-1:0] minute_step(input logic [MIN_W-1:0] v, input logic up);
    if (up) return (v >= MAX_MINUTE) ? '0 : v + 1'b1;
    return (v == '0 || v > MAX_MINUTE) ? MAX_MINUTE : v - 1'b1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button inputs, live time from the clock counter, and the set/field-select outputs.
interface time_set_ctrl_if;

  logic                             btn_mode;
  logic                             btn_up;
  logic                             btn_down;
  logic [time_set_pkg::HOUR_W-1:0]  cur_hours;
  logic [time_set_pkg::MIN_W-1:0]   cur_minutes;
  logic                             set_time_mode;
  logic [time_set_pkg::HOUR_W-1:0]  set_hours;
  logic [time_set_pkg::MIN_W-1:0]   set_minutes;
  logic [1:0]                       edit_field;

  modport slave (
    input  btn_mode, btn_up, btn_down, cur_hours, cur_minutes,
    output set_time_mode, set_hours, set_minutes, edit_field
  );

  modport master (
    output btn_mode, btn_up, btn_down, cur_hours, cur_minutes,
    input  set_time_mode, set_hours, set_minutes, edit_field
  );

endinterface

// File: rtl/btn_debounce.sv
// 2-FF synchronizer, counting debouncer and press-edge event; auto-repeat under TIME_SET_AUTO_REPEAT_EN.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
`ifdef TIME_SET_AUTO_REPEAT_EN
  input  logic i_rpt_en,
  input  logic i_rpt_clr,
`endif
  output logic o_event
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            r_sync1, r_sync2;
  logic            r_level, r_level_q;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_press;

  // The level flips on the sample after the disagreement count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      if (r_sync2 == r_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
        r_level  <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_press = r_level & ~r_level_q;

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_rpt_armed;
  logic             w_rpt_fire;

  assign w_rpt_fire = i_rpt_en & r_level &
                      (r_rpt_cnt == (r_rpt_armed ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
    end else if (!(i_rpt_en && r_level) || i_rpt_clr) begin
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
    end else if (w_rpt_fire) begin
      r_rpt_cnt   <= RPT_W'(1);
      r_rpt_armed <= 1'b1;
    end else begin
      r_rpt_cnt   <= r_rpt_cnt + 1'b1;
    end
  end

  assign o_event = w_press | w_rpt_fire;
`else
  assign o_event = w_press;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven hours/minutes editor feeding the clock counter's set port; commit held COMMIT_HOLD cycles.
// Optional auto-repeat on held up/down buttons is enabled by defining TIME_SET_AUTO_REPEAT_EN.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COMMIT_HOLD     = 8,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  time_set_ctrl_if.slave     bus
);

  localparam int CMT_W = $clog2(COMMIT_HOLD + 1);

  logic              w_mode_ev, w_up_ev, w_dn_ev;
  logic              w_step_up, w_step_dn;
  state_e            r_state, w_state;
  logic [HOUR_W-1:0] r_hours, w_hours;
  logic [MIN_W-1:0]  r_minutes, w_minutes;
  logic [CMT_W-1:0]  r_commit_cnt, w_commit_cnt;
  logic              r_set_mode;
  field_e            r_field;

`ifdef TIME_SET_AUTO_REPEAT_EN
  logic w_rpt_en, w_rpt_clr;
  assign w_rpt_en  = (r_state == EDIT_HOUR) || (r_state == EDIT_MIN);
  assign w_rpt_clr = (w_state != r_state);

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_db_mode (.clk(clk), .rst_n(rst_n), .i_btn(bus.btn_mode), .i_rpt_en(1'b0), .i_rpt_clr(1'b0), .o_event(w_mode_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_db_up (.clk(clk), .rst_n(rst_n), .i_btn(bus.btn_up), .i_rpt_en(w_rpt_en), .i_rpt_clr(w_rpt_clr), .o_event(w_up_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_db_down (.clk(clk), .rst_n(rst_n), .i_btn(bus.btn_down), .i_rpt_en(w_rpt_en), .i_rpt_clr(w_rpt_clr), .o_event(w_dn_ev));
`else
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_db_mode (.clk(clk), .rst_n(rst_n), .i_btn(bus.btn_mode), .o_event(w_mode_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_db_up (.clk(clk), .rst_n(rst_n), .i_btn(bus.btn_up), .o_event(w_up_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_db_down (.clk(clk), .rst_n(rst_n), .i_btn(bus.btn_down), .o_event(w_dn_ev));
`endif

  // Mode outranks up/down; up and down together cancel.
  assign w_step_up = w_up_ev & ~w_dn_ev & ~w_mode_ev;
  assign w_step_dn = w_dn_ev & ~w_up_ev & ~w_mode_ev;

  always_comb begin
    w_state      = r_state;
    w_hours      = r_hours;
    w_minutes    = r_minutes;
    w_commit_cnt = r_commit_cnt;
    case (r_state)
      IDLE: begin
        if (w_mode_ev) begin
          w_state   = EDIT_HOUR;
          w_hours   = (bus.cur_hours   <= MAX_HOUR)   ? bus.cur_hours   : '0;
          w_minutes = (bus.cur_minutes <= MAX_MINUTE) ? bus.cur_minutes : '0;
        end
      end
      EDIT_HOUR: begin
        if (w_mode_ev)      w_state = EDIT_MIN;
        else if (w_step_up) w_hours = hour_step(r_hours, 1'b1);
        else if (w_step_dn) w_hours = hour_step(r_hours, 1'b0);
      end
      EDIT_MIN: begin
        if (w_mode_ev) begin
          w_state      = COMMIT;
          w_commit_cnt = CMT_W'(COMMIT_HOLD - 1);
        end else if (w_step_up) begin
          w_minutes = minute_step(r_minutes, 1'b1);
        end else if (w_step_dn) begin
          w_minutes = minute_step(r_minutes, 1'b0);
        end
      end
      COMMIT: begin
        if (r_commit_cnt == '0) w_state      = IDLE;
        else                    w_commit_cnt = r_commit_cnt - 1'b1;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hours      <= '0;
      r_minutes    <= '0;
      r_commit_cnt <= '0;
      r_set_mode   <= 1'b0;
      r_field      <= FIELD_NONE;
    end else begin
      r_state      <= w_state;
      r_hours      <= w_hours;
      r_minutes    <= w_minutes;
      r_commit_cnt <= w_commit_cnt;
      r_set_mode   <= (w_state != IDLE);
      r_field      <= field_of(w_state);
    end
  end

  assign bus.set_time_mode = r_set_mode;
  assign bus.set_hours     = r_hours;
  assign bus.set_minutes   = r_minutes;
  assign bus.edit_field    = r_field;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven time-setting controller that drives the set interface of the 24-hour clock counter (`set_time_mode`, `set_hours`, `set_minutes`). It debounces three push-buttons (mode/up/down) and steps through editing hours, then minutes. It then holds the set request long enough for the slow 1 Hz counter to capture it. It runs on the fast system clock, upstream of the clock counter, and also feeds field-select to the display blinker.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples needed to change a debounced button level.
- `COMMIT_HOLD`, 8: cycles `set_time_mode` stays high after minutes are confirmed. Must be at least one 1 Hz period in fast-clock cycles.
- `REPEAT_DELAY`, 32: hold time before auto-repeat starts. Used only with `TIME_SET_AUTO_REPEAT_EN`.
- `REPEAT_PERIOD`, 8: interval between auto-repeat steps. Used only with `TIME_SET_AUTO_REPEAT_EN`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_mode`  in  1  raw mode button, asynchronous, active-high.
- `btn_up`  in  1  raw increment button, asynchronous, active-high.
- `btn_down`  in  1  raw decrement button, asynchronous, active-high.
- `cur_hours`  in  5  live hours from clock counter, 0–23.
- `cur_minutes`  in  6  live minutes from clock counter, 0–59.
- `set_time_mode`  out  1  set request to clock counter.
- `set_hours`  out  5  hours value to load.
- `set_minutes`  out  6  minutes value to load.
- `edit_field`  out  2  00 none, 01 hours, 10 minutes, 11 committing.

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal synchronized samples. A press event is a one-cycle pulse on the debounced rising edge; releases produce no event.
- FSM states: IDLE, EDIT_HOUR, EDIT_MIN, COMMIT.
- IDLE + mode event → EDIT_HOUR. In the same edge, `set_hours`←`cur_hours` and `set_minutes`←`cur_minutes`.
- EDIT_HOUR + mode event → EDIT_MIN.
- EDIT_MIN + mode event → COMMIT; the commit counter loads `COMMIT_HOLD`-1.
- COMMIT: the counter decrements each cycle. At 0 → IDLE. All button events are ignored in COMMIT.
- Up/down events in EDIT_HOUR act on `set_hours`: up 23→0, else +1; down 0→23, else −1.
- Up/down events in EDIT_MIN act on `set_minutes`: up 59→0, else +1; down 0→59, else −1.
- Up/down events in IDLE are ignored.
- Simultaneous events:
  - mode has priority; concurrent up/down is discarded.
  - up and down in the same cycle with no mode: both are discarded.
- `set_time_mode` = 1 in EDIT_HOUR, EDIT_MIN and COMMIT; 0 in IDLE. The clock counter therefore loads the edited values continuously and holds seconds at 0 while editing.
- `set_hours` and `set_minutes` hold their last value in IDLE.
- Values are always kept in range. No out-of-range value is ever driven, even if `cur_*` is out of range at capture: an out-of-range capture loads 0.

## Timing
- Reset values: `set_time_mode`=0, `set_hours`=0, `set_minutes`=0, `edit_field`=00, state IDLE.
- On reset, synchronizers, debounced levels, repeat counters and the commit counter are all cleared to 0.
- Reset asserted mid-edit or mid-commit: outputs return to reset values immediately (asynchronously). No commit completes.
- Latency, clean press (raw input rises just before edge 0):
  - debounced level is high after edge `DEBOUNCE_CYCLES`+2;
  - the press pulse is high for the following cycle;
  - the FSM/value update is visible after edge `DEBOUNCE_CYCLES`+3.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized samples produces no event.
- COMMIT lasts exactly `COMMIT_HOLD` cycles. `set_time_mode` falls on the edge that enters IDLE.
- All outputs are registered.

## Configuration
- `TIME_SET_AUTO_REPEAT_EN` defined:
  - while up or down is held debounced-high in an edit state, an extra event fires `REPEAT_DELAY` cycles after the initial press event;
  - further events fire every `REPEAT_PERIOD` cycles until release;
  - repeat counters reset on release or on any state change.
- Macro undefined: exactly one step per press. The repeat counters and their parameters have no effect, and no repeat logic is synthesized.

## Structure
- Package `time_set_pkg` holds:
  - the state enum (IDLE, EDIT_HOUR, EDIT_MIN, COMMIT);
  - `edit_field` encodings;
  - constants `MAX_HOUR`=23 and `MAX_MINUTE`=59;
  - widths `HOUR_W`=5 and `MIN_W`=6.
- One sub-module, `btn_debounce`, instantiated three times. It contains the synchronizer, debouncer, press pulse, and (under the macro) the repeat generator.

## Test plan
- Reset with `cur_hours`=10, `cur_minutes`=30; press mode → after `DEBOUNCE_CYCLES`+3 cycles `edit_field`=01, `set_time_mode`=1, `set_hours`=10, `set_minutes`=30.
- In EDIT_HOUR at 23: press up → `set_hours`=0; press down → 23.
- Press mode; in EDIT_MIN at 0: press down → `set_minutes`=59; press up → 0.
- Press mode from EDIT_MIN → `edit_field`=11 for exactly 8 cycles with `set_time_mode`=1, then IDLE with `set_time_mode`=0 and values retained.
- Glitches: 2-cycle pulse on `btn_up` → no change. Up and down pressed together → no change. Mode and up together in EDIT_HOUR → advances to EDIT_MIN with hours unchanged.
- `rst_n` low during COMMIT → all outputs 0 immediately; with the macro defined, holding up for 32+2×8 cycles past the first event yields +4 total.
